// File: rtl/branch_resolver.sv
// Fetch-side branch/jump resolver: decodes control-flow opcodes, evaluates flags and
// reports redirects to the PC decider, then squashes the wrong-path slots already fetched.
module branch_resolver #(
   parameter int          SQUASH_CYCLES = 1,
   parameter logic [5:0]  OP_JMP        = 6'b000001,
   parameter logic [5:0]  OP_BEQ        = 6'b000010,
   parameter logic [5:0]  OP_BNE        = 6'b000011,
   parameter logic [5:0]  OP_BLT        = 6'b000100
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [9:0]  iIP,
   input  logic [15:0] iInstruction,
   input  logic        iInstrValid,
   input  logic        iStall,
   input  logic        iZero,
   input  logic        iNegative,
   output logic        oBranchTaken,
   output logic        oJumpTaken,
   output logic [9:0]  oBranchAddress,
   output logic [9:0]  oTargetIP,
   output logic        oInstrValidOut
);

   typedef enum logic {RUN, SQUASH} state_t;

   localparam logic [2:0] SQUASH_INIT = 3'(SQUASH_CYCLES);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        bt_q, bt_d;
   logic        jt_q, jt_d;
   logic [9:0]  addr_q, addr_d;
   logic [9:0]  tgt_q, tgt_d;
   logic        vout_q, vout_d;

   logic [5:0]  opcode;
   logic        cond_true;

   // Sign-magnitude offset: bit 5 selects direction, bits 4:0 the distance; wraps mod 1024.
   function automatic logic [9:0] branch_target(input logic [9:0] ip, input logic [5:0] off);
      logic [9:0] mag;
      mag = {5'b0, off[4:0]};
      return off[5] ? (ip - mag) : (ip + mag);
   endfunction

   assign opcode = iInstruction[15:10];

   always_comb begin
      cond_true = 1'b0;
      case (opcode)
         OP_BEQ:  cond_true = iZero;
         OP_BNE:  cond_true = ~iZero;
         OP_BLT:  cond_true = iNegative;
         default: cond_true = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bt_d    = 1'b0;
      jt_d    = 1'b0;
      addr_d  = addr_q;
      tgt_d   = tgt_q;
      vout_d  = 1'b0;

      if (iStall) begin
         // Freeze everything, including pulses, so nothing is lost or repeated.
         bt_d   = bt_q;
         jt_d   = jt_q;
         vout_d = vout_q;
      end else begin
         case (state_q)
            RUN: begin
               if (iInstrValid) begin
                  vout_d = 1'b1;
                  tgt_d  = iIP + 10'd1;
                  if (opcode == OP_JMP) begin
                     jt_d    = 1'b1;
                     addr_d  = iInstruction[9:0];
                     tgt_d   = iInstruction[9:0];
                     state_d = SQUASH;
                     cnt_d   = SQUASH_INIT;
                  end else if (cond_true) begin
                     bt_d    = 1'b1;
                     addr_d  = {4'b0, iInstruction[5:0]};
                     tgt_d   = branch_target(iIP, iInstruction[5:0]);
                     state_d = SQUASH;
                     cnt_d   = SQUASH_INIT;
                  end
               end
            end
            SQUASH: begin
               // Each non-stalled cycle here consumes one wrong-path slot.
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         bt_q    <= 1'b0;
         jt_q    <= 1'b0;
         addr_q  <= 10'd0;
         tgt_q   <= 10'd0;
         vout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bt_q    <= bt_d;
         jt_q    <= jt_d;
         addr_q  <= addr_d;
         tgt_q   <= tgt_d;
         vout_q  <= vout_d;
      end
   end

   assign oBranchTaken   = bt_q;
   assign oJumpTaken     = jt_q;
   assign oBranchAddress = addr_q;
   assign oTargetIP      = tgt_q;
   assign oInstrValidOut = vout_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: single-cycle decode table plus squash/stall/reset sequences.
module tb_branch_resolver;

   logic        Clock;
   logic        Reset;
   logic [9:0]  iIP;
   logic [15:0] iInstruction;
   logic        iInstrValid;
   logic        iStall;
   logic        iZero;
   logic        iNegative;

   logic        bt1, jt1, vo1;
   logic [9:0]  addr1, tgt1;
   logic        bt2, jt2, vo2;
   logic [9:0]  addr2, tgt2;

   int checks;
   int errors;

   branch_resolver dut (
      .Clock(Clock), .Reset(Reset), .iIP(iIP), .iInstruction(iInstruction),
      .iInstrValid(iInstrValid), .iStall(iStall), .iZero(iZero), .iNegative(iNegative),
      .oBranchTaken(bt1), .oJumpTaken(jt1), .oBranchAddress(addr1),
      .oTargetIP(tgt1), .oInstrValidOut(vo1)
   );

   branch_resolver #(.SQUASH_CYCLES(2)) dut2 (
      .Clock(Clock), .Reset(Reset), .iIP(iIP), .iInstruction(iInstruction),
      .iInstrValid(iInstrValid), .iStall(iStall), .iZero(iZero), .iNegative(iNegative),
      .oBranchTaken(bt2), .oJumpTaken(jt2), .oBranchAddress(addr2),
      .oTargetIP(tgt2), .oInstrValidOut(vo2)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [9:0]  ip;
      logic [15:0] instr;
      logic        valid;
      logic        z;
      logic        n;
      logic        bt;
      logic        jt;
      logic [9:0]  addr;
      logic [9:0]  tgt;
      logic        vout;
   } vec_t;

   vec_t vecs[11];

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic [9:0] ip, input logic [15:0] instr,
                        input logic valid, input logic z, input logic n);
      iIP          = ip;
      iInstruction = instr;
      iInstrValid  = valid;
      iZero        = z;
      iNegative    = n;
   endtask

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit use2, input logic ebt, input logic ejt,
                             input logic [9:0] eaddr, input logic [9:0] etgt, input logic evout);
      logic       bt, jt, vo;
      logic [9:0] a, t;
      if (use2) begin
         bt = bt2; jt = jt2; vo = vo2; a = addr2; t = tgt2;
      end else begin
         bt = bt1; jt = jt1; vo = vo1; a = addr1; t = tgt1;
      end
      chk($sformatf("%s.branch", tag), {9'b0, bt}, {9'b0, ebt});
      chk($sformatf("%s.jump", tag),   {9'b0, jt}, {9'b0, ejt});
      chk($sformatf("%s.addr", tag),   a, eaddr);
      chk($sformatf("%s.target", tag), t, etgt);
      chk($sformatf("%s.valid", tag),  {9'b0, vo}, {9'b0, evout});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Reset  = 1'b0;
      iStall = 1'b0;
      drive(10'h000, 16'h0000, 1'b0, 1'b0, 1'b0);

      //                ip      instr     vld  z     n     bt    jt    addr     tgt      vout
      vecs[0]  = '{10'h010, 16'h06A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2A5, 10'h2A5, 1'b1}; // JMP
      vecs[1]  = '{10'h003, 16'h0825, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h025, 10'h3FE, 1'b1}; // BEQ -5 wrap
      vecs[2]  = '{10'h003, 16'h0825, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h004, 1'b1}; // BEQ not taken
      vecs[3]  = '{10'h3FF, 16'h1002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h002, 10'h001, 1'b1}; // BLT +2 wrap
      vecs[4]  = '{10'h3FF, 16'h0C02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1}; // BNE not taken
      vecs[5]  = '{10'h100, 16'h0C07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h007, 10'h107, 1'b1}; // BNE +7
      vecs[6]  = '{10'h055, 16'h0820, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h020, 10'h055, 1'b1}; // BEQ -0
      vecs[7]  = '{10'h020, 16'h0BC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h003, 10'h023, 1'b1}; // [9:6] ignored
      vecs[8]  = '{10'h200, 16'hFC12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 10'h201, 1'b1}; // other opcode
      vecs[9]  = '{10'h010, 16'h06A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0}; // not valid
      vecs[10] = '{10'h040, 16'h1003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h041, 1'b1}; // BLT not taken

      // Reset held with stall and a valid jump on the bus
      Reset  = 1'b1;
      iStall = 1'b1;
      drive(10'h010, 16'h06A5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0);
      end
      Reset  = 1'b0;
      iStall = 1'b0;
      drive(10'h003, 16'h0825, 1'b1, 1'b1, 1'b0);
      step();
      check_outs("post_rst", 1'b0, 1'b1, 1'b0, 10'h025, 10'h3FE, 1'b1);

      // Table of single-instruction decodes, each from a fresh reset
      for (int i = 0; i < 11; i++) begin
         Reset = 1'b1;
         step();
         Reset = 1'b0;
         drive(vecs[i].ip, vecs[i].instr, vecs[i].valid, vecs[i].z, vecs[i].n);
         step();
         check_outs($sformatf("vec%0d", i), 1'b0, vecs[i].bt, vecs[i].jt,
                    vecs[i].addr, vecs[i].tgt, vecs[i].vout);
      end

      // Jump, squashed BEQ slot, then normal decode and hold behaviour
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      drive(10'h010, 16'h06A5, 1'b1, 1'b0, 1'b0);
      step();
      check_outs("jmp", 1'b0, 1'b0, 1'b1, 10'h2A5, 10'h2A5, 1'b1);
      drive(10'h2A5, 16'h0803, 1'b1, 1'b1, 1'b0);
      step();
      check_outs("jmp_sq", 1'b0, 1'b0, 1'b0, 10'h2A5, 10'h2A5, 1'b0);
      step();
      check_outs("jmp_after", 1'b0, 1'b1, 1'b0, 10'h003, 10'h2A8, 1'b1);
      drive(10'h2A8, 16'h0803, 1'b0, 1'b1, 1'b0);
      step();
      check_outs("br_sq", 1'b0, 1'b0, 1'b0, 10'h003, 10'h2A8, 1'b0);
      step();
      check_outs("hold_inv", 1'b0, 1'b0, 1'b0, 10'h003, 10'h2A8, 1'b0);
      drive(10'h300, 16'h0803, 1'b1, 1'b0, 1'b0);
      step();
      check_outs("nt_keep", 1'b0, 1'b0, 1'b0, 10'h003, 10'h301, 1'b1);

      // Two-slot squash interleaved with stalls
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      drive(10'h010, 16'h0555, 1'b1, 1'b0, 1'b0);
      step();
      check_outs("s2_jmp", 1'b1, 1'b0, 1'b1, 10'h155, 10'h155, 1'b1);
      iStall = 1'b1;
      drive(10'h155, 16'h0803, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         check_outs($sformatf("s2_hold%0d", i), 1'b1, 1'b0, 1'b1, 10'h155, 10'h155, 1'b1);
      end
      iStall = 1'b0;
      step();
      check_outs("s2_slot1", 1'b1, 1'b0, 1'b0, 10'h155, 10'h155, 1'b0);
      iStall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("s2_mid%0d", i), 1'b1, 1'b0, 1'b0, 10'h155, 10'h155, 1'b0);
      end
      iStall = 1'b0;
      step();
      check_outs("s2_slot2", 1'b1, 1'b0, 1'b0, 10'h155, 10'h155, 1'b0);
      step();
      check_outs("s2_resume", 1'b1, 1'b1, 1'b0, 10'h003, 10'h158, 1'b1);

      // Reset during squash
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      drive(10'h010, 16'h0555, 1'b1, 1'b0, 1'b0);
      step();
      check_outs("rs_jmp", 1'b1, 1'b0, 1'b1, 10'h155, 10'h155, 1'b1);
      Reset = 1'b1;
      drive(10'h155, 16'h0803, 1'b1, 1'b1, 1'b0);
      step();
      check_outs("rs_rst", 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0);
      Reset = 1'b0;
      step();
      check_outs("rs_decode", 1'b1, 1'b1, 1'b0, 10'h003, 10'h158, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
